countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_pkg.sv | 13 +
 rtl/countdown_timer_if.sv | 38 +++
 rtl/countdown_timer.sv | 97 +++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer.
// State encoding and its width.
package countdown_pkg;

    localparam int StateW = 2;

    typedef enum logic [StateW-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, control and status bundle for countdown_timer.
// The timer connects through the slave modport.
interface countdown_timer_if #(
    parameter int Size = 5
);

    logic            load_valid;
    logic            load_ready;
    logic [Size-1:0] load_value;
    logic            pause;
    logic            abort;
    logic [Size-1:0] count;
    logic            busy;
    logic            done;

    modport master (
        output load_valid,
        output load_value,
        output pause,
        output abort,
        input  load_ready,
        input  count,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  load_value,
        input  pause,
        input  abort,
        output load_ready,
        output count,
        output busy,
        output done
    );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control and pause/abort.
// Define COUNTDOWN_AUTORELOAD_EN for periodic reload from the last load.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int Size = 5
) (
    input  logic               clock,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam logic [Size-1:0] Zero = '0;
    localparam logic [Size-1:0] One  = {{(Size-1){1'b0}}, 1'b1};

    state_t          state;
    state_t          state_nxt;
    logic [Size-1:0] count_q;
    logic [Size-1:0] count_nxt;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [Size-1:0] reload_q;
    logic [Size-1:0] reload_nxt;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count_q <= Zero;
        end else begin
            state   <= state_nxt;
            count_q <= count_nxt;
        end
    end

`ifdef COUNTDOWN_AUTORELOAD_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reload_q <= Zero;
        end else begin
            reload_q <= reload_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
`ifdef COUNTDOWN_AUTORELOAD_EN
        reload_nxt = reload_q;
`endif
        unique case (state)
            IDLE: begin
                if (bus.load_valid) begin
                    count_nxt = bus.load_value;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    reload_nxt = bus.load_value;
`endif
                    if (bus.load_value != Zero) begin
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                // Abort wins over pause; the count is left where it stopped.
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (!bus.pause && count_q != Zero) begin
                    count_nxt = count_q - One;
                    if (count_q == One) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
                if (!bus.abort && reload_q != Zero) begin
                    state_nxt = RUN;
                    count_nxt = reload_q;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.load_ready = (state == IDLE);
    assign bus.busy       = (state == RUN) || (state == DONE);
    assign bus.done       = (state == DONE);
    assign bus.count      = count_q;

endmodule
